// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war rope core.
package tow_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HOLD  = 2'd1,
    WIN   = 2'd2
  } tow_state_e;

  localparam int WINS_W = 4;

  function automatic int center(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/tow_flasher.sv
// Win-state LED flasher: blinks the rope marker while the game is won.
// Only compiled when TOW_WIN_FLASH_EN is defined.
`ifdef TOW_WIN_FLASH_EN
module tow_flasher #(
  parameter int N_POS   = 9,
  parameter int FLASH_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win_entry_i,
  input  logic             in_win_i,
  input  logic [N_POS-1:0] leds_i,
  output logic [N_POS-1:0] leds_o
);

  logic [FLASH_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || win_entry_i) begin
      cnt_q <= '0;
    end else if (in_win_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // MSB splits the counter period into equal on and off halves.
  assign leds_o = (in_win_i && cnt_q[FLASH_W-1]) ? '0 : leds_i;

endmodule
`endif

// File: rtl/tow_rope_fsm.sv
// Tug-of-war rope core: moves a one-hot marker on latch-stage decisions,
// re-arms the latch via clear, detects wins. Optional TOW_WIN_FLASH_EN blinks the win LED.
module tow_rope_fsm
  import tow_pkg::*;
#(
  parameter int N_POS    = 9,
  parameter int COOLDOWN = 16,
  parameter int FLASH_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              tie,
  input  logic              right,
  input  logic              pb_l,
  input  logic              pb_r,
  input  logic              new_game,
  output logic              clear,
  output logic [N_POS-1:0]  leds,
  output logic              game_over,
  output logic              winner_right,
  output logic [WINS_W-1:0] wins_l,
  output logic [WINS_W-1:0] wins_r,
  output logic [1:0]        dbg_state
);

  localparam int POS_W = $clog2(N_POS);
  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam logic [POS_W-1:0] POS_C   = POS_W'(center(N_POS));
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);
  localparam logic [CD_W-1:0]  CD_INIT = CD_W'(COOLDOWN - 1);

  if (N_POS < 5 || (N_POS % 2) == 0 || COOLDOWN < 1 || FLASH_W < 1) begin : g_bad_param
    $error("tow_rope_fsm: illegal parameter combination");
  end

  function automatic logic [N_POS-1:0] marker(input logic [POS_W-1:0] p);
    return N_POS'(1) << p;
  endfunction

  tow_state_e        state_q;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [CD_W-1:0]   cd_q;
  logic              clear_q, go_q, wr_q;
  logic [WINS_W-1:0] wins_l_q, wins_r_q;
  logic [N_POS-1:0]  leds_q;
  logic              at_end, win_entry;

  always_comb begin
    pos_d = pos_q;
    if (!tie) begin
      pos_d = right ? pos_q + 1'b1 : pos_q - 1'b1;
    end
  end

  assign at_end    = (pos_d == '0) || (pos_d == POS_MAX);
  assign win_entry = (state_q == ARMED) && push && at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      pos_q    <= POS_C;
      leds_q   <= marker(POS_C);
      cd_q     <= CD_INIT;
      clear_q  <= 1'b1;
      go_q     <= 1'b0;
      wr_q     <= 1'b0;
      wins_l_q <= '0;
      wins_r_q <= '0;
    end else begin
      case (state_q)
        ARMED: begin
          // push takes priority; new_game is meaningless outside WIN
          if (push) begin
            pos_q   <= pos_d;
            leds_q  <= marker(pos_d);
            cd_q    <= CD_INIT;
            clear_q <= 1'b1;
            if (at_end) begin
              state_q <= WIN;
              go_q    <= 1'b1;
              wr_q    <= (pos_d == POS_MAX);
              if (pos_d == POS_MAX) begin
                if (!(&wins_r_q)) wins_r_q <= wins_r_q + 1'b1;
              end else begin
                if (!(&wins_l_q)) wins_l_q <= wins_l_q + 1'b1;
              end
            end else begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cd_q != '0) begin
            cd_q <= cd_q - 1'b1;
          end else if (!pb_l && !pb_r) begin
            state_q <= ARMED;
            clear_q <= 1'b0;
          end
        end
        WIN: begin
          if (new_game) begin
            state_q <= HOLD;
            pos_q   <= POS_C;
            leds_q  <= marker(POS_C);
            cd_q    <= CD_INIT;
            go_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= HOLD;
          clear_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef TOW_WIN_FLASH_EN
  tow_flasher #(
    .N_POS   (N_POS),
    .FLASH_W (FLASH_W)
  ) u_flasher (
    .clk         (clk),
    .rst         (rst),
    .win_entry_i (win_entry),
    .in_win_i    (state_q == WIN),
    .leds_i      (leds_q),
    .leds_o      (leds)
  );
`else
  logic unused_win_entry;
  assign unused_win_entry = win_entry;
  assign leds = leds_q;
`endif

  assign clear        = clear_q;
  assign game_over    = go_q;
  assign winner_right = wr_q;
  assign wins_l       = wins_l_q;
  assign wins_r       = wins_r_q;
  assign dbg_state    = state_q;

endmodule
